// File: rtl/perf_pkg.sv
// Shared constants, state encoding and helpers for the performance-counter dumper.
package perf_pkg;

    localparam int CNT_W         = 32;
    localparam int NUM_CNT       = 7;
    localparam logic [7:0] HDR_BYTE = 8'hA5;
    localparam int BYTES_PER_CNT = CNT_W / 8;
    localparam int NUM_BYTES     = NUM_CNT * BYTES_PER_CNT;
    localparam int IDX_W         = $clog2(NUM_BYTES);
    localparam int SEL_W         = $clog2(NUM_CNT);
    localparam int BSEL_W        = $clog2(BYTES_PER_CNT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    localparam int CNT_INSTR    = 0;
    localparam int CNT_LOADS    = 1;
    localparam int CNT_STORES   = 2;
    localparam int CNT_ALUS     = 3;
    localparam int CNT_CONTROLS = 4;
    localparam int CNT_CYCLES   = 5;
    localparam int CNT_STALL    = 6;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        DATA  = 3'd2,
        CKSUM = 3'd3,
        FIN   = 3'd4
    } state_t;

    function automatic logic [7:0] cksum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/perf_counter_dumper_snapshot_mux.sv
// Snapshot register file for all counters plus the byte-select mux over the frame payload.
module perf_snapshot_mux
    import perf_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             capture,
    input  logic [CNT_W-1:0] cnt_in [NUM_CNT],
    input  logic [IDX_W-1:0] idx,
    output logic [7:0]       byte_out
);

    logic [CNT_W-1:0]  snap_r [NUM_CNT];
    logic [SEL_W-1:0]  sel_s;
    logic [BSEL_W-1:0] bsel_s;

    // Capture every counter on the same edge so the frame is one coherent sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                snap_r[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                snap_r[i] <= cnt_in[i];
            end
        end
    end

    // Payload byte k: counter k/BYTES_PER_CNT, least-significant byte first.
    always_comb begin
        sel_s    = SEL_W'(idx / IDX_W'(BYTES_PER_CNT));
        bsel_s   = BSEL_W'(idx % IDX_W'(BYTES_PER_CNT));
        byte_out = snap_r[sel_s][{bsel_s, 3'b000} +: 8];
    end

endmodule

// File: rtl/perf_counter_dumper.sv
// Snapshots the seven performance counters on dump_req and streams them as a framed byte stream.
// Optional macro PERF_DUMP_CHECKSUM_EN appends an XOR checksum byte to each frame.
module perf_counter_dumper
    import perf_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dump_req,
    input  logic [CNT_W-1:0] total_instructions,
    input  logic [CNT_W-1:0] total_loads,
    input  logic [CNT_W-1:0] total_stores,
    input  logic [CNT_W-1:0] total_alus,
    input  logic [CNT_W-1:0] total_controls,
    input  logic [CNT_W-1:0] total_cycles,
    input  logic [CNT_W-1:0] total_stall_cycles,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             req_dropped
);

    state_t           state_r, state_s;
    logic [IDX_W-1:0] idx_r, idx_s;
    logic [CNT_W-1:0] cnt_s [NUM_CNT];
    logic             capture_s;
    logic             xfer_s;
    logic [7:0]       byte_s;
    logic [7:0]       data_s;
    logic             valid_s;
`ifdef PERF_DUMP_CHECKSUM_EN
    logic [7:0]       cksum_r;
`endif

    assign cnt_s[CNT_INSTR]    = total_instructions;
    assign cnt_s[CNT_LOADS]    = total_loads;
    assign cnt_s[CNT_STORES]   = total_stores;
    assign cnt_s[CNT_ALUS]     = total_alus;
    assign cnt_s[CNT_CONTROLS] = total_controls;
    assign cnt_s[CNT_CYCLES]   = total_cycles;
    assign cnt_s[CNT_STALL]    = total_stall_cycles;

    // The mux is addressed with the next index so the byte is ready to register with its state.
    perf_snapshot_mux u_snap (
        .clk      (clk),
        .rst_n    (rst_n),
        .capture  (capture_s),
        .cnt_in   (cnt_s),
        .idx      (idx_s),
        .byte_out (byte_s)
    );

    // Next-state and next-output logic; holding state while stalled keeps out_data/out_valid frozen.
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        capture_s = 1'b0;
        xfer_s    = out_valid & out_ready;
        case (state_r)
            IDLE: begin
                if (dump_req) begin
                    state_s   = HDR;
                    idx_s     = '0;
                    capture_s = 1'b1;
                end else begin
                    state_s   = IDLE;
                end
            end
            HDR: begin
                if (xfer_s) begin
                    state_s = DATA;
                end else begin
                    state_s = HDR;
                end
            end
            DATA: begin
                if (xfer_s && (idx_r == LAST_IDX)) begin
`ifdef PERF_DUMP_CHECKSUM_EN
                    state_s = CKSUM;
`else
                    state_s = FIN;
`endif
                end else if (xfer_s) begin
                    idx_s = idx_r + IDX_W'(1);
                end else begin
                    state_s = DATA;
                end
            end
            CKSUM: begin
`ifdef PERF_DUMP_CHECKSUM_EN
                if (xfer_s) begin
                    state_s = FIN;
                end else begin
                    state_s = CKSUM;
                end
`else
                state_s = IDLE;
                idx_s   = '0;
`endif
            end
            FIN: begin
                state_s = IDLE;
                idx_s   = '0;
            end
            default: begin
                state_s = IDLE;
                idx_s   = '0;
            end
        endcase

        valid_s = (state_s == HDR) || (state_s == DATA) || (state_s == CKSUM);
        case (state_s)
            HDR:     data_s = HDR_BYTE;
            DATA:    data_s = byte_s;
`ifdef PERF_DUMP_CHECKSUM_EN
            CKSUM:   data_s = (state_r == CKSUM) ? out_data : cksum_step(cksum_r, out_data);
`endif
            default: data_s = 8'h00;
        endcase
    end

    // State, index and registered stream outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            idx_r       <= '0;
            out_valid   <= 1'b0;
            out_data    <= 8'h00;
            busy        <= 1'b0;
            done        <= 1'b0;
            req_dropped <= 1'b0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            out_valid   <= valid_s;
            out_data    <= data_s;
            busy        <= (state_s != IDLE);
            done        <= (state_s == FIN);
            req_dropped <= req_dropped | (dump_req & (state_r != IDLE));
        end
    end

`ifdef PERF_DUMP_CHECKSUM_EN
    // Running XOR of the header and every accepted payload byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cksum_r <= 8'h00;
        end else if (capture_s) begin
            cksum_r <= HDR_BYTE;
        end else if (xfer_s && (state_r == DATA)) begin
            cksum_r <= cksum_step(cksum_r, out_data);
        end
    end
`endif

endmodule

// File: tb/tb_perf_counter_dumper.sv
// Scoreboard bench: dumps push reference frames into a queue, a negedge monitor pops on each transfer.
module tb_perf_counter_dumper;
    import perf_pkg::*;

`ifdef PERF_DUMP_CHECKSUM_EN
    localparam int FRAME_LEN = NUM_BYTES + 2;
    localparam int LAT       = 30;
    localparam bit HAS_CK    = 1'b1;
`else
    localparam int FRAME_LEN = NUM_BYTES + 1;
    localparam int LAT       = 29;
    localparam bit HAS_CK    = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             dump_req;
    logic             out_ready;
    logic [CNT_W-1:0] cnt [NUM_CNT];
    logic [7:0]       out_data;
    logic             out_valid, busy, done, req_dropped;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         xfer_cnt = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         req_cyc = 0;
    int         ready_mode = 0;
    logic [7:0] exp_q [$];

    logic       prev_stall = 1'b0;
    logic       prev_xfer = 1'b0;
    logic       prev_done = 1'b0;
    logic [7:0] prev_data = 8'h00;

    perf_counter_dumper dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .dump_req           (dump_req),
        .total_instructions (cnt[0]),
        .total_loads        (cnt[1]),
        .total_stores       (cnt[2]),
        .total_alus         (cnt[3]),
        .total_controls     (cnt[4]),
        .total_cycles       (cnt[5]),
        .total_stall_cycles (cnt[6]),
        .out_data           (out_data),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .busy               (busy),
        .done               (done),
        .req_dropped        (req_dropped)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference frame: header, counters 0..6 each LSB first, then optional XOR of everything.
    function automatic void push_frame();
        logic [7:0] ck;
        logic [7:0] b;
        ck = HDR_BYTE;
        exp_q.push_back(HDR_BYTE);
        for (int c = 0; c < NUM_CNT; c++) begin
            for (int k = 0; k < BYTES_PER_CNT; k++) begin
                b  = 8'(cnt[c] >> (8 * k));
                ck = ck ^ b;
                exp_q.push_back(b);
            end
        end
        if (HAS_CK) exp_q.push_back(ck);
    endfunction

    // Sink readiness: always, 1-0-0 pattern, or random.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((cyc % 3) == 0);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: compares every accepted byte against the scoreboard and watches handshake rules.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            prev_xfer  = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold_valid", 32'(out_valid), 32'd1);
                check("stall_hold_data", 32'(out_data), 32'(prev_data));
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_after_last_byte", 32'({prev_xfer, exp_q.size() == 0}), 32'd3);
            end
            if (prev_done) begin
                check("done_single_pulse", 32'({done, busy}), 32'd0);
            end
            if (out_valid) begin
                check("busy_while_valid", 32'(busy), 32'd1);
            end
            if (out_valid && out_ready) begin
                xfer_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte actual=%0h expected=none (cycle %0d)", out_data, cyc);
                end else if (out_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL stream_byte actual=%0h expected=%0h (cycle %0d)", out_data, exp_q[0], cyc);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_xfer  = out_valid && out_ready;
            prev_done  = done;
            prev_data  = out_data;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_pattern();
        logic [7:0] v;
        for (int i = 0; i < NUM_CNT; i++) begin
            v      = 8'(8'h11 * (i + 1));
            cnt[i] = CNT_W'({4{v}});
        end
    endtask

    task automatic set_random();
        for (int i = 0; i < NUM_CNT; i++) cnt[i] = $urandom();
    endtask

    task automatic issue(input bit accept);
        dump_req = 1'b1;
        req_cyc  = cyc + 1;
        if (accept) push_frame();
        tick(1);
        dump_req = 1'b0;
    endtask

    task automatic wait_done(input string name, input bit churn);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < 400) begin
            tick(1);
            n++;
            if (churn) begin
                for (int i = 0; i < NUM_CNT; i++) cnt[i] = $urandom();
                cnt[CNT_CYCLES] = cnt[CNT_CYCLES] + 1;
            end
        end
        check({name, "_done_seen"}, 32'(done_cnt - start), 32'd1);
    endtask

    initial begin
        int xb;
        int n;
        rst_n    = 1'b0;
        dump_req = 1'b0;
        for (int i = 0; i < NUM_CNT; i++) cnt[i] = '0;
        tick(3);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_req_dropped", 32'(req_dropped), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Pattern frame with an always-ready sink: latency and length.
        ready_mode = 0;
        set_pattern();
        xb = xfer_cnt;
        issue(1'b1);
        wait_done("basic", 1'b0);
        check("basic_done_latency", 32'(done_cyc - req_cyc), 32'(LAT));
        check("basic_frame_len", 32'(xfer_cnt - xb), 32'(FRAME_LEN));

        // Same frame with a stalling sink.
        ready_mode = 1;
        tick(2);
        xb = xfer_cnt;
        issue(1'b1);
        wait_done("stall", 1'b0);
        check("stall_frame_len", 32'(xfer_cnt - xb), 32'(FRAME_LEN));

        // Inputs churn every cycle during the dump.
        ready_mode = 2;
        tick(2);
        set_random();
        xb = xfer_cnt;
        issue(1'b1);
        wait_done("churn", 1'b1);
        check("churn_frame_len", 32'(xfer_cnt - xb), 32'(FRAME_LEN));

        // Request 5 cycles into a dump is dropped; a later one works.
        ready_mode = 0;
        tick(2);
        set_random();
        issue(1'b1);
        tick(4);
        issue(1'b0);
        check("dropped_flag_set", 32'(req_dropped), 32'd1);
        wait_done("drop_frame", 1'b0);
        tick(2);
        set_random();
        xb = xfer_cnt;
        issue(1'b1);
        wait_done("after_drop", 1'b0);
        check("after_drop_len", 32'(xfer_cnt - xb), 32'(FRAME_LEN));
        check("dropped_flag_sticky", 32'(req_dropped), 32'd1);

        // Reset in the middle of a frame.
        tick(2);
        set_random();
        xb = xfer_cnt;
        issue(1'b1);
        n = 0;
        while ((xfer_cnt - xb) < 10 && n < 100) begin
            tick(1);
            n++;
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_req_dropped", 32'(req_dropped), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick(6);
        check("postrst_idle_valid", 32'(out_valid), 32'd0);
        check("postrst_idle_busy", 32'(busy), 32'd0);
        set_random();
        xb = xfer_cnt;
        issue(1'b1);
        wait_done("postrst", 1'b0);
        check("postrst_frame_len", 32'(xfer_cnt - xb), 32'(FRAME_LEN));

        // Request coincident with done is dropped.
        tick(2);
        set_random();
        issue(1'b1);
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            tick(1);
            n++;
        end
        check("coinc_done_seen", 32'(done), 32'd1);
        dump_req = 1'b1;
        tick(1);
        dump_req = 1'b0;
        tick(6);
        check("coinc_no_frame_busy", 32'(busy), 32'd0);
        check("coinc_no_frame_valid", 32'(out_valid), 32'd0);
        check("coinc_req_dropped", 32'(req_dropped), 32'd1);

        // A few random frames with a random sink.
        ready_mode = 2;
        for (int f = 0; f < 4; f++) begin
            set_random();
            xb = xfer_cnt;
            issue(1'b1);
            wait_done("rand", 1'b0);
            check("rand_frame_len", 32'(xfer_cnt - xb), 32'(FRAME_LEN));
            tick(1 + int'($urandom_range(0, 3)));
        end

        tick(3);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule
